cia_serial_peer: RTL and testbench
==================================

CIA_SERIAL_PEER -- requirements
Module: cia_serial_peer

Interface
REQ-001 SHALL provide parameter CNT_HALF, default 4, as the number of phi2_p ticks per CNT half-period when transmitting (legal range 2..255).
REQ-002 SHALL provide parameter RX_TIMEOUT, default 255, as the number of phi2_p ticks without a CNT rising edge, mid-byte, before the receive is abandoned.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port res_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port phi2_p, input, 1, one-clk-wide Phi2 positive-edge enable; all state advances only on clk cycles where phi2_p=1.
REQ-006 SHALL have port dir, input, 1: 1 = peer transmits (CIA in input mode), 0 = peer receives (CIA in output mode).
REQ-007 SHALL have ports tx_valid (input, 1), tx_data (input, 8) and tx_ready (output, 1) forming the transmit byte handshake.
REQ-008 SHALL have ports rx_valid (output, 1) and rx_data (output, 8); rx_valid is a one-tick strobe marking a received byte.
REQ-009 SHALL have port rx_err, output, 1, a one-tick strobe marking a receive timeout.
REQ-010 SHALL have port busy, output, 1, high while a byte is in transfer in either direction.
REQ-011 SHALL have ports sp_in and cnt_in, inputs, 1 each, the CIA SP and CNT lines.
REQ-012 SHALL have ports sp_out and cnt_out, outputs, 1 each, open-collector style drive with 1 = released.

Function
REQ-013 SHALL pass cnt_in and sp_in through a 2-flop synchronizer clocked on phi2_p ticks; a CNT rising edge is synchronized cnt low on the previous tick and high on the current tick.
REQ-014 SHALL implement the TX state machine IDLE -> TX_LO -> TX_HI -> (TX_LO | IDLE).
REQ-015 SHALL drive tx_ready = (state==IDLE) & dir & ~res-active; a byte is accepted on a phi2_p tick where tx_valid & tx_ready.
REQ-016 On accept, SHALL load the shift register, set sp_out = tx_data[7], set cnt_out = 0, set bit count = 0, and enter TX_LO.
REQ-017 SHALL hold TX_LO for CNT_HALF ticks, then set cnt_out = 1 and enter TX_HI; the CIA samples SP on this rising edge.
REQ-018 SHALL hold TX_HI for CNT_HALF ticks, then shift the data left (MSB first); if bit count < 7, drive the next bit on sp_out with cnt_out = 0 and return to TX_LO; otherwise release sp_out = 1 and return to IDLE.
REQ-019 One byte transmission SHALL take exactly 16*CNT_HALF ticks from accept to IDLE, producing 8 CNT rising edges.
REQ-020 While dir = 0, on each synchronized CNT rising edge the receiver SHALL shift the synchronized sp_in into the LSB (MSB-first order).
REQ-021 On the 8th receive edge, SHALL update rx_data with the assembled byte, pulse rx_valid for one tick, and clear the bit count.
REQ-022 A dir change SHALL, on the same tick, abort any transfer: TX to IDLE with sp_out = cnt_out = 1, RX bit count cleared, no rx_valid issued.
REQ-023 busy SHALL be 1 in TX_LO/TX_HI and whenever the RX bit count is nonzero.
REQ-024 While dir = 0, cnt_out and sp_out SHALL remain 1.

Reset
REQ-025 Reset values: sp_out = 1, cnt_out = 1, tx_ready = 0, rx_valid = 0, rx_err = 0, rx_data = 0x00, busy = 0, state = IDLE, synchronizer flops = 1.
REQ-026 Reset asserted mid-byte SHALL discard the byte immediately and release both lines asynchronously.

Configuration
REQ-027 With CIA_PEER_TIMEOUT_EN defined, SHALL count phi2_p ticks since the last RX edge while the bit count is nonzero; on reaching RX_TIMEOUT it SHALL clear the bit count and pulse rx_err.
REQ-028 Without CIA_PEER_TIMEOUT_EN, SHALL omit the counter, tie rx_err to 0, and hold partial bytes indefinitely.

Structure
REQ-029 Package cia_peer_pkg SHALL hold the TX state enum, the CNT_HALF/RX_TIMEOUT defaults and the byte width constant.
REQ-030 SHALL instantiate one sub-module cia_peer_sync (2-flop synchronizer plus rising-edge detect), used for CNT and SP.

Verification
REQ-031 dir = 1, CNT_HALF = 4, send 0xA5 -> 8 cnt_out rising edges 8 ticks apart; sp_out at the edges = 1,0,1,0,0,1,0,1; IDLE after 64 ticks; tx_ready high again.
REQ-032 dir = 0, CIA-model shifts 0x3C with edges every 6 ticks -> single rx_valid with rx_data = 0x3C; busy low afterwards.
REQ-033 dir = 0, 3 edges then silence for 300 ticks -> rx_err pulse at tick 255 after the last edge (macro on); with the macro off, no pulse and busy stays 1.
REQ-034 dir = 1 sending 0xFF, dir toggled to 0 after 3 edges -> cnt_out = sp_out = 1 on the same tick, no further edges, tx_ready low.
REQ-035 res_n pulsed low mid-TX -> outputs at reset values without waiting for phi2_p; a subsequent 0x81 send completes correctly.

Source files
------------

// File: rtl/cia_peer_pkg.sv
// Shared types and defaults for the CIA serial-port peer.
// The optional receive timeout is enabled by defining CIA_PEER_TIMEOUT_EN.
package cia_peer_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned CNT_HALF_DEF   = 4;
    localparam int unsigned RX_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        StIdle,
        StTxLo,
        StTxHi
    } tx_state_e;

endpackage

// File: rtl/cia_peer_if.sv
// Byte-level handshake between the host logic and the CIA serial peer.
interface cia_peer_if
    import cia_peer_pkg::*;
();

    logic              tx_valid;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_err;
    logic              busy;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, rx_valid, rx_data, rx_err, busy
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, rx_valid, rx_data, rx_err, busy
    );

endinterface

// File: rtl/cia_peer_sync.sv
// Two-flop synchronizer advanced on phi2 ticks, with rising-edge detect on the MSB line.
module cia_peer_sync #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic         phi2_p,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic         rise
);

    logic [W-1:0] s1_q, s2_q;
    logic         prev_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            s1_q   <= '1;
            s2_q   <= '1;
            prev_q <= 1'b1;
        end else if (phi2_p) begin
            s1_q   <= din;
            s2_q   <= s1_q;
            prev_q <= s2_q[W-1];
        end
    end

    assign level = s2_q;
    // Held between ticks so the next phi2 tick consumes it exactly once
    assign rise  = s2_q[W-1] & ~prev_q;

endmodule

// File: rtl/cia_serial_peer.sv
// Serial peer for a CIA SP/CNT port: drives CNT when transmitting, follows it when receiving.
// Define CIA_PEER_TIMEOUT_EN to abandon stalled partial receive bytes and flag rx_err.
module cia_serial_peer
    import cia_peer_pkg::*;
#(
    parameter int unsigned CNT_HALF   = CNT_HALF_DEF,
    parameter int unsigned RX_TIMEOUT = RX_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2_p,
    input  logic       dir,
    cia_peer_if.slave  bus,
    input  logic       sp_in,
    input  logic       cnt_in,
    output logic       sp_out,
    output logic       cnt_out
);

    if (CNT_HALF < 2 || CNT_HALF > 255 || RX_TIMEOUT < 2) begin : g_bad_param
        $error("cia_serial_peer: parameter out of range");
    end

    localparam logic [7:0] HalfLast = 8'(CNT_HALF - 1);

    tx_state_e         state_q, state_d;
    logic [7:0]        half_q, half_d;
    logic [2:0]        tx_bits_q, tx_bits_d;
    logic [BYTE_W-1:0] tx_sh_q, tx_sh_d;
    logic              sp_q, sp_d, cnt_q, cnt_d;
    logic              dir_q;
    logic [2:0]        rx_bits_q, rx_bits_d;
    logic [BYTE_W-1:0] rx_sh_q, rx_sh_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [1:0]        sync_lvl;
    logic              cnt_rise, dir_chg;

`ifdef CIA_PEER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [TW-1:0] ToLast = TW'(RX_TIMEOUT - 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          rx_err_q, rx_err_d;
`endif

    cia_peer_sync #(.W(2)) u_sync (
        .clk    (clk),
        .res_n  (res_n),
        .phi2_p (phi2_p),
        .din    ({cnt_in, sp_in}),
        .level  (sync_lvl),
        .rise   (cnt_rise)
    );

    assign dir_chg = dir ^ dir_q;

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        tx_bits_d  = tx_bits_q;
        tx_sh_d    = tx_sh_q;
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        rx_bits_d  = rx_bits_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
`ifdef CIA_PEER_TIMEOUT_EN
        timer_d    = timer_q;
        rx_err_d   = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.tx_valid && dir) begin
                    tx_sh_d   = bus.tx_data;
                    sp_d      = bus.tx_data[BYTE_W-1];
                    cnt_d     = 1'b0;
                    tx_bits_d = 3'd0;
                    half_d    = 8'd0;
                    state_d   = StTxLo;
                end
            end
            StTxLo: begin
                if (half_q == HalfLast) begin
                    half_d  = 8'd0;
                    cnt_d   = 1'b1;
                    state_d = StTxHi;
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            StTxHi: begin
                if (half_q == HalfLast) begin
                    half_d  = 8'd0;
                    tx_sh_d = tx_sh_q << 1;
                    if (tx_bits_q != 3'd7) begin
                        sp_d      = tx_sh_q[BYTE_W-2];
                        cnt_d     = 1'b0;
                        tx_bits_d = tx_bits_q + 3'd1;
                        state_d   = StTxLo;
                    end else begin
                        sp_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (dir_chg && state_q != StIdle) begin
            state_d = StIdle;
            sp_d    = 1'b1;
            cnt_d   = 1'b1;
        end

        if (dir_chg) begin
            rx_bits_d = 3'd0;
        end else if (!dir && cnt_rise) begin
            rx_sh_d = {rx_sh_q[BYTE_W-2:0], sync_lvl[0]};
            if (rx_bits_q == 3'd7) begin
                rx_data_d  = rx_sh_d;
                rx_valid_d = 1'b1;
                rx_bits_d  = 3'd0;
            end else begin
                rx_bits_d = rx_bits_q + 3'd1;
            end
        end

`ifdef CIA_PEER_TIMEOUT_EN
        if (dir_chg || (!dir && cnt_rise) || rx_bits_q == 3'd0) begin
            timer_d = '0;
        end else if (timer_q == ToLast) begin
            timer_d   = '0;
            rx_bits_d = 3'd0;
            rx_err_d  = 1'b1;
        end else begin
            timer_d = timer_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= StIdle;
            half_q     <= 8'd0;
            tx_bits_q  <= 3'd0;
            tx_sh_q    <= '0;
            sp_q       <= 1'b1;
            cnt_q      <= 1'b1;
            dir_q      <= 1'b0;
            rx_bits_q  <= 3'd0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (phi2_p) begin
            state_q    <= state_d;
            half_q     <= half_d;
            tx_bits_q  <= tx_bits_d;
            tx_sh_q    <= tx_sh_d;
            sp_q       <= sp_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir;
            rx_bits_q  <= rx_bits_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

`ifdef CIA_PEER_TIMEOUT_EN
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            timer_q  <= '0;
            rx_err_q <= 1'b0;
        end else if (phi2_p) begin
            timer_q  <= timer_d;
            rx_err_q <= rx_err_d;
        end
    end
    assign bus.rx_err = rx_err_q;
`else
    assign bus.rx_err = 1'b0;
`endif

    // Lines are forced released whenever the CIA is the talker
    assign sp_out       = sp_q | ~dir;
    assign cnt_out      = cnt_q | ~dir;
    assign bus.tx_ready = (state_q == StIdle) & dir & res_n;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.busy     = (state_q != StIdle) | (rx_bits_q != 3'd0);

endmodule

// File: tb/tb_cia_serial_peer.sv
// Self-checking bench for cia_serial_peer; honours CIA_PEER_TIMEOUT_EN like the design.
module tb_cia_serial_peer;

    localparam int HALF = 4;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic phi2_p;
    logic dir = 1'b1;
    logic sp_in = 1'b1;
    logic cnt_in = 1'b1;
    logic sp_out, cnt_out;
    int   div = 0;
    int   tick_n = 0;

    int          n_assert = 0;
    int          n_fail = 0;
    int          rx_seen = 0;
    int          err_seen = 0;
    int          err_tick = 0;
    int          last_edge = 0;
    logic [7:0]  rx_last = 8'h00;

    cia_peer_if bus ();

    cia_serial_peer #(.CNT_HALF(HALF), .RX_TIMEOUT(255)) dut (
        .clk     (clk),
        .res_n   (res_n),
        .phi2_p  (phi2_p),
        .dir     (dir),
        .bus     (bus),
        .sp_in   (sp_in),
        .cnt_in  (cnt_in),
        .sp_out  (sp_out),
        .cnt_out (cnt_out)
    );

    always #5 clk = ~clk;
    always @(negedge clk) div <= (div + 1) % 4;
    assign phi2_p = (div == 3);

    always @(posedge clk) begin
        if (phi2_p) begin
            tick_n <= tick_n + 1;
            if (bus.rx_valid) begin
                rx_seen <= rx_seen + 1;
                rx_last <= bus.rx_data;
            end
            if (bus.rx_err) begin
                err_seen <= err_seen + 1;
                err_tick <= tick_n;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (phi2_p !== 1'b1) @(posedge clk);
        #1;
    endtask

    // action: 0 = run to completion, 1 = flip dir after stop_edges, 2 = reset after stop_edges
    task automatic tx_byte(input logic [7:0] b, input int stop_edges, input int action);
        int   t0, edges, w, extra;
        logic prev_cnt, done;
        w = 0;
        while (bus.tx_ready !== 1'b1 && w < 50) begin
            wait_tick();
            w++;
        end
        check("tx_ready_before", bus.tx_ready, 1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        wait_tick();
        t0 = tick_n;
        bus.tx_valid = 1'b0;
        check("accept_cnt_low", cnt_out, 0);
        check("accept_sp_msb", sp_out, b[7]);
        check("accept_busy", bus.busy, 1);
        prev_cnt = 1'b0;
        edges = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            wait_tick();
            if (cnt_out && !prev_cnt) begin
                if (edges < 8) begin
                    check("edge_time", tick_n - t0, (2 * edges + 1) * HALF);
                    check("edge_sp", sp_out, b[7 - edges]);
                end
                edges++;
                if (edges == stop_edges && action == 1) begin
                    dir = 1'b0;
                    #1;
                    check("abort_cnt", cnt_out, 1);
                    check("abort_sp", sp_out, 1);
                    check("abort_ready", bus.tx_ready, 0);
                    extra = 0;
                    prev_cnt = cnt_out;
                    for (int k = 0; k < 40; k++) begin
                        wait_tick();
                        if (cnt_out && !prev_cnt) extra++;
                        prev_cnt = cnt_out;
                    end
                    check("abort_no_edges", extra, 0);
                    check("abort_busy", bus.busy, 0);
                    done = 1'b1;
                end else if (edges == stop_edges && action == 2) begin
                    #3;
                    res_n = 1'b0;
                    #1;
                    check("rst_sp", sp_out, 1);
                    check("rst_cnt", cnt_out, 1);
                    check("rst_ready", bus.tx_ready, 0);
                    check("rst_busy", bus.busy, 0);
                    check("rst_rx_data", bus.rx_data, 0);
                    check("rst_rx_valid", bus.rx_valid, 0);
                    #20;
                    res_n = 1'b1;
                    done = 1'b1;
                end
            end
            prev_cnt = cnt_out;
            if (!done && bus.tx_ready) begin
                check("tx_done_ticks", tick_n - t0, 16 * HALF);
                check("tx_edge_count", edges, 8);
                check("tx_busy_after", bus.busy, 0);
                done = 1'b1;
            end
        end
        if (!done) check("tx_timeout", 0, 1);
    endtask

    // CIA in output mode: presents bit, then raises CNT mid-cell
    task automatic cia_shift(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sp_in  = b[7 - i];
            cnt_in = 1'b0;
            repeat (3) wait_tick();
            cnt_in = 1'b1;
            last_edge = tick_n;
            repeat (3) wait_tick();
        end
    endtask

    initial begin
        int         r0, e0, dt;
        logic [7:0] rb;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        #37;
        check("reset_sp", sp_out, 1);
        check("reset_cnt", cnt_out, 1);
        check("reset_ready", bus.tx_ready, 0);
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_rx_err", bus.rx_err, 0);
        check("reset_rx_data", bus.rx_data, 0);
        check("reset_busy", bus.busy, 0);
        res_n = 1'b1;
        repeat (3) wait_tick();
        check("ready_after_reset", bus.tx_ready, 1);

        tx_byte(8'hA5, 0, 0);
        for (int n = 0; n < 2; n++) tx_byte(8'($urandom_range(0, 255)), 0, 0);

        dir = 1'b0;
        repeat (4) wait_tick();
        check("rx_mode_ready", bus.tx_ready, 0);
        check("rx_mode_cnt", cnt_out, 1);
        r0 = rx_seen;
        cia_shift(8'h3C, 8);
        repeat (5) wait_tick();
        check("rx_count_3c", rx_seen - r0, 1);
        check("rx_last_3c", rx_last, 8'h3C);
        check("rx_data_3c", bus.rx_data, 8'h3C);
        check("rx_busy_3c", bus.busy, 0);
        for (int n = 0; n < 3; n++) begin
            rb = 8'($urandom_range(0, 255));
            r0 = rx_seen;
            cia_shift(rb, 8);
            repeat (5) wait_tick();
            check("rx_count_rand", rx_seen - r0, 1);
            check("rx_data_rand", bus.rx_data, rb);
        end

        r0 = rx_seen;
        e0 = err_seen;
        cia_shift(8'h5A, 3);
        check("partial_busy", bus.busy, 1);
        repeat (300) wait_tick();
        dt = err_tick - last_edge;
`ifdef CIA_PEER_TIMEOUT_EN
        check("timeout_pulse", err_seen - e0, 1);
        check("timeout_window", (dt >= 255 && dt <= 262), 1);
        check("timeout_busy", bus.busy, 0);
`else
        check("no_timeout_pulse", err_seen - e0, 0);
        check("no_timeout_busy", bus.busy, 1);
`endif
        check("timeout_no_rx", rx_seen - r0, 0);
        dir = 1'b1;
        repeat (2) wait_tick();
        check("dir_clears_rx", bus.busy, 0);

        tx_byte(8'hFF, 3, 1);
        dir = 1'b1;
        repeat (3) wait_tick();
        tx_byte(8'($urandom_range(0, 255)), 4, 2);
        tx_byte(8'h81, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
